// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor decode-stage control slice.
package bp_pkg;

   typedef enum logic [0:0] {
      RUN        = 1'b0,
      WAIT_FLAGS = 1'b1
   } bp_state_e;

   localparam logic [1:0]  PRED_SNT = 2'b00;
   localparam logic [1:0]  PRED_WT  = 2'b10;
   localparam logic [1:0]  PRED_ST  = 2'b11;
   localparam logic [15:0] PC_INC   = 16'h0002;

   // Taken/not-taken direction is carried in the MSB of the 2-bit prediction.
   function automatic logic pred_taken(input logic [1:0] pred);
      return pred[1];
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Count register with saturation at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Decode-stage branch resolution: IF/ID prediction registers, predictor
// write pulses, PC redirect/flush, stall gating and performance counters.
module branch_resolve_ctrl
   import bp_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ext_stall,
   input  logic [15:0]      pc_curr,
   input  logic [1:0]       pred_f,
   input  logic [15:0]      pred_target_f,
   input  logic             id_is_branch,
   input  logic             id_flags_ready,
   input  logic             id_cond_true,
   input  logic [15:0]      id_target,
   output logic             bp_enable,
   output logic             pc_write_en,
   output logic             update_pc,
   output logic [15:0]      update_target,
   output logic [15:0]      if_id_pc,
   output logic [1:0]       if_id_prediction,
   output logic             if_id_valid,
   output logic             wen_bht,
   output logic             wen_btb,
   output logic             actual_taken,
   output logic [15:0]      actual_target,
   output logic [CNT_W-1:0] cnt_branches,
   output logic [CNT_W-1:0] cnt_mispredicts,
   output logic [CNT_W-1:0] cnt_stalls
);

   bp_state_e   state_r;
   logic [15:0] if_id_target_r;

   logic resolve_s;
   logic taken_s;
   logic mispred_s;
   logic tgt_miss_s;
   logic stall_s;
   logic redirect_s;

   // Resolution happens combinationally in the decode cycle; reset suppresses it.
   always_comb begin
      taken_s    = id_cond_true;
      stall_s    = ext_stall | (if_id_valid & id_is_branch & ~id_flags_ready);
      resolve_s  = ~rst & if_id_valid & id_is_branch & id_flags_ready & ~ext_stall;
      mispred_s  = pred_taken(if_id_prediction) != taken_s;
      tgt_miss_s = if_id_target_r != id_target;
      redirect_s = resolve_s & ((taken_s & (mispred_s | tgt_miss_s)) |
                                (~taken_s & pred_taken(if_id_prediction)));
   end

   assign wen_bht       = resolve_s & mispred_s;
   assign wen_btb       = resolve_s & taken_s & tgt_miss_s;
   assign actual_taken  = taken_s;
   assign actual_target = taken_s ? id_target : 16'h0000;
   assign update_pc     = redirect_s;
   assign update_target = taken_s ? id_target : (if_id_pc + PC_INC);
   assign bp_enable     = ~stall_s;
   assign pc_write_en   = ~stall_s | redirect_s;

   // Flag-wait tracking; ext_stall freezes the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= RUN;
      end else begin
         case (state_r)
            RUN: begin
               if (if_id_valid && id_is_branch && !id_flags_ready && !ext_stall) begin
                  state_r <= WAIT_FLAGS;
               end else begin
                  state_r <= RUN;
               end
            end
            WAIT_FLAGS: begin
               if (id_flags_ready && !ext_stall) begin
                  state_r <= RUN;
               end else begin
                  state_r <= WAIT_FLAGS;
               end
            end
            default: state_r <= RUN;
         endcase
      end
   end

   // IF/ID pipeline registers: a redirect flushes, otherwise load unless stalled.
   always_ff @(posedge clk) begin
      if (rst || redirect_s) begin
         if_id_pc         <= 16'h0000;
         if_id_prediction <= PRED_SNT;
         if_id_target_r   <= 16'h0000;
         if_id_valid      <= 1'b0;
      end else if (!stall_s) begin
         if_id_pc         <= pc_curr;
         if_id_prediction <= pred_f;
         if_id_target_r   <= pred_target_f;
         if_id_valid      <= 1'b1;
      end else begin
         if_id_pc         <= if_id_pc;
         if_id_prediction <= if_id_prediction;
         if_id_target_r   <= if_id_target_r;
         if_id_valid      <= if_id_valid;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_cnt_branches (
      .clk   (clk),
      .rst   (rst),
      .inc   (resolve_s),
      .count (cnt_branches)
   );

   sat_counter #(.CNT_W(CNT_W)) u_cnt_mispredicts (
      .clk   (clk),
      .rst   (rst),
      .inc   (redirect_s),
      .count (cnt_mispredicts)
   );

   sat_counter #(.CNT_W(CNT_W)) u_cnt_stalls (
      .clk   (clk),
      .rst   (rst),
      .inc   (~pc_write_en),
      .count (cnt_stalls)
   );

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl; narrow counters keep saturation short.
module tb_branch_resolve_ctrl;
   import bp_pkg::*;

   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          ext_stall;
   logic [15:0]   pc_curr;
   logic [1:0]    pred_f;
   logic [15:0]   pred_target_f;
   logic          id_is_branch;
   logic          id_flags_ready;
   logic          id_cond_true;
   logic [15:0]   id_target;
   logic          bp_enable;
   logic          pc_write_en;
   logic          update_pc;
   logic [15:0]   update_target;
   logic [15:0]   if_id_pc;
   logic [1:0]    if_id_prediction;
   logic          if_id_valid;
   logic          wen_bht;
   logic          wen_btb;
   logic          actual_taken;
   logic [15:0]   actual_target;
   logic [CW-1:0] cnt_branches;
   logic [CW-1:0] cnt_mispredicts;
   logic [CW-1:0] cnt_stalls;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   branch_resolve_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .ext_stall(ext_stall), .pc_curr(pc_curr),
      .pred_f(pred_f), .pred_target_f(pred_target_f), .id_is_branch(id_is_branch),
      .id_flags_ready(id_flags_ready), .id_cond_true(id_cond_true), .id_target(id_target),
      .bp_enable(bp_enable), .pc_write_en(pc_write_en), .update_pc(update_pc),
      .update_target(update_target), .if_id_pc(if_id_pc), .if_id_prediction(if_id_prediction),
      .if_id_valid(if_id_valid), .wen_bht(wen_bht), .wen_btb(wen_btb),
      .actual_taken(actual_taken), .actual_target(actual_target),
      .cnt_branches(cnt_branches), .cnt_mispredicts(cnt_mispredicts), .cnt_stalls(cnt_stalls)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Put one non-branch fetch into IF/ID.
   task automatic load(input logic [15:0] pc, input logic [1:0] pr, input logic [15:0] tg);
      ext_stall = 1'b0; id_is_branch = 1'b0; id_flags_ready = 1'b0;
      pc_curr = pc; pred_f = pr; pred_target_f = tg;
      tick();
   endtask

   initial begin
      rst = 1'b1; ext_stall = 1'b0; pc_curr = 16'h0000; pred_f = 2'b00;
      pred_target_f = 16'h0000; id_is_branch = 1'b0; id_flags_ready = 1'b0;
      id_cond_true = 1'b0; id_target = 16'h0000;
      tick(); tick();
      rst = 1'b0;

      // 1: reset in the middle of a flag wait
      load(16'h0008, PRED_ST, 16'h0200);
      id_is_branch = 1'b1; id_flags_ready = 1'b0;
      #2; check("wait_stall_pcwe", 32'(pc_write_en), 32'd0);
      tick();
      check("enter_wait", 32'(dut.state_r), 32'(WAIT_FLAGS));
      rst = 1'b1; id_flags_ready = 1'b1; id_cond_true = 1'b0;
      #2;
      check("rst_wen_bht", 32'(wen_bht), 32'd0);
      check("rst_update_pc", 32'(update_pc), 32'd0);
      tick(); tick();
      rst = 1'b0;
      #1;
      check("rst_state", 32'(dut.state_r), 32'(RUN));
      check("rst_valid", 32'(if_id_valid), 32'd0);
      check("rst_pc", 32'(if_id_pc), 32'd0);
      check("rst_pred", 32'(if_id_prediction), 32'd0);
      check("rst_cnt_br", 32'(cnt_branches), 32'd0);
      check("rst_cnt_mp", 32'(cnt_mispredicts), 32'd0);
      check("rst_cnt_st", 32'(cnt_stalls), 32'd0);
      check("rst_wen_btb", 32'(wen_btb), 32'd0);

      // 2: predicted not-taken, resolves not-taken
      load(16'h0010, PRED_SNT, 16'h0000);
      id_is_branch = 1'b1; id_flags_ready = 1'b1; id_cond_true = 1'b0; id_target = 16'h0040;
      pc_curr = 16'h0012;
      #2;
      check("t2_wen_bht", 32'(wen_bht), 32'd0);
      check("t2_wen_btb", 32'(wen_btb), 32'd0);
      check("t2_update_pc", 32'(update_pc), 32'd0);
      check("t2_pcwe", 32'(pc_write_en), 32'd1);
      check("t2_act_tgt", 32'(actual_target), 32'd0);
      tick();
      check("t2_cnt_br", 32'(cnt_branches), 32'd1);
      check("t2_next_pc", 32'(if_id_pc), 32'h0012);

      // 3: predicted not-taken, actually taken
      load(16'h0010, PRED_SNT, 16'h0000);
      id_is_branch = 1'b1; id_flags_ready = 1'b1; id_cond_true = 1'b1; id_target = 16'h0040;
      #2;
      check("t3_wen_bht", 32'(wen_bht), 32'd1);
      check("t3_wen_btb", 32'(wen_btb), 32'd1);
      check("t3_update_pc", 32'(update_pc), 32'd1);
      check("t3_target", 32'(update_target), 32'h0040);
      check("t3_act_taken", 32'(actual_taken), 32'd1);
      check("t3_act_tgt", 32'(actual_target), 32'h0040);
      tick();
      check("t3_flush", 32'(if_id_valid), 32'd0);
      check("t3_cnt_mp", 32'(cnt_mispredicts), 32'd1);
      check("t3_cnt_br", 32'(cnt_branches), 32'd2);

      // 4: strongly taken at top of memory, resolves not-taken; fallthrough wraps
      load(16'hFFFE, PRED_ST, 16'h0100);
      id_is_branch = 1'b1; id_flags_ready = 1'b1; id_cond_true = 1'b0; id_target = 16'h0100;
      #2;
      check("t4_wen_bht", 32'(wen_bht), 32'd1);
      check("t4_wen_btb", 32'(wen_btb), 32'd0);
      check("t4_update_pc", 32'(update_pc), 32'd1);
      check("t4_target", 32'(update_target), 32'h0000);
      tick();
      check("t4_cnt_mp", 32'(cnt_mispredicts), 32'd2);
      check("t4_cnt_br", 32'(cnt_branches), 32'd3);

      // 5: three flag-wait cycles, then a correctly predicted taken branch
      load(16'h0020, PRED_ST, 16'h0080);
      id_is_branch = 1'b1; id_flags_ready = 1'b0; id_cond_true = 1'b1; id_target = 16'h0080;
      pc_curr = 16'h0022;
      for (int i = 0; i < 3; i++) begin
         #2;
         check("t5_pcwe", 32'(pc_write_en), 32'd0);
         check("t5_bp_en", 32'(bp_enable), 32'd0);
         tick();
         check("t5_hold_pc", 32'(if_id_pc), 32'h0020);
      end
      check("t5_state", 32'(dut.state_r), 32'(WAIT_FLAGS));
      id_flags_ready = 1'b1;
      #2;
      check("t5_upd", 32'(update_pc), 32'd0);
      check("t5_wen_bht", 32'(wen_bht), 32'd0);
      check("t5_wen_btb", 32'(wen_btb), 32'd0);
      check("t5_pcwe_res", 32'(pc_write_en), 32'd1);
      tick();
      check("t5_cnt_st", 32'(cnt_stalls), 32'd3);
      check("t5_cnt_br", 32'(cnt_branches), 32'd4);
      check("t5_state_run", 32'(dut.state_r), 32'(RUN));
      check("t5_load", 32'(if_id_pc), 32'h0022);

      // 6: ext_stall overrides ready flags, then resolution next cycle
      load(16'h0030, PRED_SNT, 16'h0000);
      id_is_branch = 1'b1; id_flags_ready = 1'b0; id_cond_true = 1'b1; id_target = 16'h0050;
      tick();
      check("t6_wait", 32'(dut.state_r), 32'(WAIT_FLAGS));
      id_flags_ready = 1'b1; ext_stall = 1'b1;
      #2;
      check("t6_st_bht", 32'(wen_bht), 32'd0);
      check("t6_st_upd", 32'(update_pc), 32'd0);
      check("t6_st_pcwe", 32'(pc_write_en), 32'd0);
      tick();
      check("t6_still_wait", 32'(dut.state_r), 32'(WAIT_FLAGS));
      check("t6_cnt_br_hold", 32'(cnt_branches), 32'd4);
      check("t6_hold_pc", 32'(if_id_pc), 32'h0030);
      ext_stall = 1'b0;
      #2;
      check("t6_wen_bht", 32'(wen_bht), 32'd1);
      check("t6_wen_btb", 32'(wen_btb), 32'd1);
      check("t6_upd", 32'(update_pc), 32'd1);
      check("t6_target", 32'(update_target), 32'h0050);
      tick();
      check("t6_cnt_br", 32'(cnt_branches), 32'd5);
      check("t6_cnt_mp", 32'(cnt_mispredicts), 32'd3);
      check("t6_cnt_st", 32'(cnt_stalls), 32'd5);
      check("t6_run", 32'(dut.state_r), 32'(RUN));
      check("t6_flush", 32'(if_id_valid), 32'd0);

      // stall counter saturation
      id_is_branch = 1'b0; ext_stall = 1'b1;
      for (int i = 0; i < 260; i++) tick();
      check("sat_stalls", 32'(cnt_stalls), 32'hFF);
      tick();
      check("sat_hold", 32'(cnt_stalls), 32'hFF);
      check("sat_br_same", 32'(cnt_branches), 32'd5);
      ext_stall = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Decode-stage controller that sequences the dynamic branch predictor (BHT + BTB) in the fetch/decode pipeline.
- Owns the IF/ID prediction pipeline registers.
- Resolves branches once condition flags are valid and compares the outcome against the pipelined prediction.
- Issues BHT/BTB write pulses, the PC redirect and the IF/ID flush.
- Gates the predictor enable and PC write during flag-wait and external stalls.
- Keeps saturating performance counters.

Parameters:
CNT_W, 16, width of each performance counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
ext_stall  in  1  global pipeline stall (memory/hazard unit)
pc_curr  in  16  fetch-stage PC
pred_f  in  2  predictor prediction for pc_curr (bit 1 = taken)
pred_target_f  in  16  predictor target for pc_curr
id_is_branch  in  1  decode instruction is a conditional branch
id_flags_ready  in  1  flags for the decode branch are valid this cycle
id_cond_true  in  1  branch condition evaluated true
id_target  in  16  computed branch target
bp_enable  out  1  predictor enable / fetch advance
pc_write_en  out  1  PC register write enable
update_pc  out  1  redirect PC to update_target
update_target  out  16  redirect address
if_id_pc  out  16  IF/ID PC; low 4 bits feed predictor IF_ID_PC_curr
if_id_prediction  out  2  IF/ID prediction
if_id_valid  out  1  IF/ID holds a real instruction
wen_bht  out  1  BHT write pulse
wen_btb  out  1  BTB write pulse
actual_taken  out  1  resolved direction to predictor
actual_target  out  16  resolved target to predictor
cnt_branches  out  CNT_W  resolved branches
cnt_mispredicts  out  CNT_W  redirects issued
cnt_stalls  out  CNT_W  cycles with pc_write_en=0

Behaviour:
Reset:
- FSM goes to RUN.
- if_id_pc=0, if_id_prediction=2'b00, if_id_valid=0, all counters 0.
- All pulse outputs 0.
- A reset mid-WAIT_FLAGS abandons the pending branch with no writes.

FSM: RUN, WAIT_FLAGS.
- RUN: if if_id_valid & id_is_branch & !id_flags_ready & !ext_stall, go to WAIT_FLAGS.
- WAIT_FLAGS: return to RUN on the cycle where id_flags_ready & !ext_stall (resolution happens in that cycle).

Definitions:
- resolve = if_id_valid & id_is_branch & id_flags_ready & !ext_stall. It is a combinational, single-cycle pulse.
- taken = id_cond_true.
- mispred = if_id_prediction[1] != taken.
- tgt_miss = if_id_predicted_target != id_target. if_id_predicted_target is an internal 16-bit IF/ID register.

Predictor writes:
- wen_bht = resolve & mispred.
- wen_btb = resolve & taken & tgt_miss.
- actual_taken = taken.
- actual_target = taken ? id_target : 16'h0000.

Redirect:
- update_pc = resolve & ((taken & (mispred | tgt_miss)) | (!taken & if_id_prediction[1])).
- update_target = taken ? id_target : if_id_pc + 2, modulo 2^16 (0xFFFE+2 = 0x0000).

Stall gating:
- stall_c = ext_stall | (if_id_valid & id_is_branch & !id_flags_ready).
- pc_write_en = bp_enable = !stall_c.
- update_pc forces pc_write_en=1.

IF/ID registers:
- On posedge with update_pc: flush. valid=0, prediction=00, predicted_target=0, pc=0.
- Else if !stall_c: load pc_curr, pred_f, pred_target_f, valid=1.
- Else: hold.

Simultaneous events:
- ext_stall wins over flags_ready: no pulses, no state change.
- Flush wins over load.

Counters:
- Increment at posedge on resolve / update_pc / !pc_write_en respectively.
- Saturate at all-ones.

Latency:
- Resolution is combinational in the decode cycle.
- Redirected fetch occurs the next cycle.
- Mispredict penalty is exactly 1 bubble.

Decomposition:
- Shared package bp_pkg: FSM enum (RUN, WAIT_FLAGS), constants PRED_SNT=2'b00, PRED_WT=2'b10, PRED_ST=2'b11, PC_INC=16'h0002.
- Sub-module sat_counter (CNT_W, inc, rst), instantiated 3 times.

Test Plan:
1. Reset asserted 2 cycles mid-WAIT_FLAGS -> FSM RUN, if_id_valid=0, all counters 0, wen_bht=wen_btb=update_pc=0.
2. IF/ID pc=0x0010, pred=00, branch not taken, flags ready -> no wen_bht, no wen_btb, no update_pc, cnt_branches=1.
3. pc=0x0010, pred=00, taken, id_target=0x0040 -> wen_bht=1, wen_btb=1, update_pc=1, update_target=0x0040, next cycle if_id_valid=0, cnt_mispredicts=1.
4. pc=0xFFFE, pred=11, predicted_target=0x0100, not taken -> wen_bht=1, wen_btb=0, update_target=0x0000.
5. Branch with id_flags_ready low for 3 cycles -> pc_write_en=0 for 3 cycles, IF/ID holds, resolve on cycle 4, cnt_stalls=3.
6. In WAIT_FLAGS, id_flags_ready=1 with ext_stall=1 -> no pulses, stays WAIT_FLAGS; with ext_stall=0 next cycle -> resolves once. Force 2^CNT_W stalls -> cnt_stalls holds at all-ones.
